instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/seq_pkg.sv | 35 +++
 rtl/instr_decode.sv | 38 +++
 rtl/instr_sequencer.sv | 134 +++++++++++++
 tb/tb_instr_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the R-type instruction sequencer.
package seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SGT  = 6'h2B;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd6;
    localparam logic [3:0] ALU_SGT = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;

    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int SH_LSB = 6;

endpackage

// File: rtl/instr_decode.sv
// Combinational funct decoder; VAR_SHIFT_EN adds the sllv/srlv/srav encodings.
module instr_decode
    import seq_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal,
    output logic       is_shift,
    output logic       is_var
);

    always_comb begin
        alu_op   = ALU_ADD;
        legal    = 1'b1;
        is_shift = 1'b0;
        is_var   = 1'b0;
        case (funct)
            F_ADD: alu_op = ALU_ADD;
            F_SUB: alu_op = ALU_SUB;
            F_AND: alu_op = ALU_AND;
            F_OR:  alu_op = ALU_OR;
            F_SGT: alu_op = ALU_SGT;
            F_SLT: alu_op = ALU_SLT;
            F_SLL: begin alu_op = ALU_SLL; is_shift = 1'b1; end
            F_SRL: begin alu_op = ALU_SRL; is_shift = 1'b1; end
            F_SRA: begin alu_op = ALU_SRA; is_shift = 1'b1; end
`ifdef VAR_SHIFT_EN
            F_SLLV: begin alu_op = ALU_SLL; is_shift = 1'b1; is_var = 1'b1; end
            F_SRLV: begin alu_op = ALU_SRL; is_shift = 1'b1; is_var = 1'b1; end
            F_SRAV: begin alu_op = ALU_SRA; is_shift = 1'b1; is_var = 1'b1; end
`endif
            default: legal = 1'b0;
        endcase
        if (op != 6'd0) legal = 1'b0;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state R-type sequencer driving register-file addresses, ALU control and writeback.
// Optional VAR_SHIFT_EN: variable shifts take their count from RsData at the DECODE->EXEC edge.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InstrValid,
    input  logic [31:0] Instr,
    output logic        InstrReady,
    input  logic [31:0] RsData,
    output logic [4:0]  RR1,
    output logic [4:0]  RR2,
    output logic [4:0]  WR,
    output logic        WE,
    output logic        MuxCtrl,
    output logic [3:0]  ALUOp,
    output logic [4:0]  ShiftCount,
    output logic        Busy,
    output logic        Done,
    output logic        IllegalInstr
);

    state_t     state;
    logic [4:0] rd_q;
    logic [3:0] alu_op;
    logic       legal, is_shift, is_var;

    logic [4:0] f_rs, f_rt, f_rd, f_sh;
    assign f_rs = Instr[RS_LSB +: 5];
    assign f_rt = Instr[RT_LSB +: 5];
    assign f_rd = Instr[RD_LSB +: 5];
    assign f_sh = Instr[SH_LSB +: 5];

    instr_decode u_dec (
        .op       (Instr[OP_LSB +: 6]),
        .funct    (Instr[5:0]),
        .alu_op   (alu_op),
        .legal    (legal),
        .is_shift (is_shift),
        .is_var   (is_var)
    );

`ifdef VAR_SHIFT_EN
    logic [4:0] rt_q;
    logic       is_var_q;
    logic       unused_bits;
    assign unused_bits = ^RsData[31:5];
`else
    logic       unused_bits;
    assign unused_bits = ^{RsData, is_var};
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= S_IDLE;
            InstrReady   <= 1'b1;
            RR1          <= '0;
            RR2          <= '0;
            WR           <= '0;
            ALUOp        <= '0;
            ShiftCount   <= '0;
            WE           <= 1'b0;
            MuxCtrl      <= 1'b0;
            Done         <= 1'b0;
            IllegalInstr <= 1'b0;
            Busy         <= 1'b0;
            rd_q         <= '0;
`ifdef VAR_SHIFT_EN
            rt_q         <= '0;
            is_var_q     <= 1'b0;
`endif
        end else begin
            WE           <= 1'b0;
            MuxCtrl      <= 1'b0;
            Done         <= 1'b0;
            IllegalInstr <= 1'b0;
            case (state)
                S_IDLE: if (InstrValid && InstrReady) begin
                    state      <= S_DECODE;
                    InstrReady <= 1'b0;
                    Busy       <= 1'b1;
                    rd_q       <= f_rd;
`ifdef VAR_SHIFT_EN
                    rt_q       <= f_rt;
                    is_var_q   <= is_var;
`endif
                    // Fixed shifts read rt on both ports; everything else reads rs/rt.
                    if (legal) begin
                        ALUOp      <= alu_op;
                        RR1        <= (is_shift && !is_var) ? f_rt : f_rs;
                        RR2        <= f_rt;
                        ShiftCount <= (is_shift && !is_var) ? f_sh : 5'd0;
                    end else begin
                        IllegalInstr <= 1'b1;
                        ALUOp        <= '0;
                        RR1          <= '0;
                        RR2          <= '0;
                        ShiftCount   <= '0;
                    end
                end
                S_DECODE: begin
                    if (IllegalInstr) begin
                        state      <= S_IDLE;
                        Busy       <= 1'b0;
                        InstrReady <= 1'b1;
                    end else begin
                        state <= S_EXEC;
`ifdef VAR_SHIFT_EN
                        if (is_var_q) begin
                            RR1        <= rt_q;
                            ShiftCount <= RsData[4:0];
                        end
`endif
                    end
                end
                S_EXEC: begin
                    state   <= S_WB;
                    WR      <= rd_q;
                    WE      <= (rd_q != 5'd0);
                    MuxCtrl <= 1'b1;
                    Done    <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    WR         <= '0;
                    Busy       <= 1'b0;
                    InstrReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a cycle-age reference model and literal spot checks.
module tb_instr_sequencer;

    logic        Clk = 1'b0;
    logic        Rst, InstrValid;
    logic [31:0] Instr, RsData;
    logic        InstrReady, WE, MuxCtrl, Busy, Done, IllegalInstr;
    logic [4:0]  RR1, RR2, WR, ShiftCount;
    logic [3:0]  ALUOp;

    int errors = 0;
    int checks = 0;

    instr_sequencer dut (
        .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .Instr(Instr),
        .InstrReady(InstrReady), .RsData(RsData), .RR1(RR1), .RR2(RR2),
        .WR(WR), .WE(WE), .MuxCtrl(MuxCtrl), .ALUOp(ALUOp),
        .ShiftCount(ShiftCount), .Busy(Busy), .Done(Done),
        .IllegalInstr(IllegalInstr)
    );

    always #5 Clk = ~Clk;

    // Reference rules straight from the opcode table.
    function automatic bit m_var(input logic [5:0] f);
`ifdef VAR_SHIFT_EN
        return (f == 6'h04 || f == 6'h06 || f == 6'h07);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_legal(input logic [31:0] w);
        logic [5:0] f;
        f = w[5:0];
        if (w[31:26] != 6'd0) return 1'b0;
        return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h00 ||
                f == 6'h02 || f == 6'h03 || f == 6'h2B || f == 6'h2A || m_var(f));
    endfunction

    function automatic logic [3:0] m_alu(input logic [5:0] f);
        case (f)
            6'h20: return 4'd0;  6'h22: return 4'd1;  6'h24: return 4'd2;
            6'h25: return 4'd3;  6'h00, 6'h04: return 4'd4;
            6'h02, 6'h06: return 4'd5;  6'h03, 6'h07: return 4'd6;
            6'h2B: return 4'd7;  default: return 4'd8;
        endcase
    endfunction

    function automatic bit m_fixed_shift(input logic [5:0] f);
        return (f == 6'h00 || f == 6'h02 || f == 6'h03);
    endfunction

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd,
                                       input int sh, input logic [5:0] f);
        logic [31:0] w;
        w = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], f};
        return w;
    endfunction

    // Model: age = cycles since acceptance (0 = idle), -1 before first edge.
    int          age = -1;
    int          cyc = 0;
    logic [31:0] mw = '0;
    logic [4:0]  mvar_sh = '0;
    int          we_cyc[$];

    always @(posedge Clk) begin
        cyc++;
        if (Rst) age = 0;
        else if (age <= 0) begin
            if (InstrValid) begin age = 1; mw = Instr; end
            else age = 0;
        end
        else if (age == 1 && !m_legal(mw)) age = 0;
        else if (age == 3) age = 0;
        else begin
            if (age == 1) mvar_sh = RsData[4:0];
            age++;
        end
    end

    always @(negedge Clk) begin
        logic [5:0]  exp_ctl, got_ctl;
        logic [18:0] exp_ops, got_ops;
        logic [4:0]  rs, rt, rd, e_rr1, e_sh;
        if (age >= 0) begin
            rs = mw[25:21]; rt = mw[20:16]; rd = mw[15:11];
            if (WE) we_cyc.push_back(cyc);
            exp_ctl = {age == 0, age >= 1, age == 1 && !m_legal(mw), age == 3,
                       age == 3 && rd != 5'd0, age == 3};
            got_ctl = {InstrReady, Busy, IllegalInstr, Done, WE, MuxCtrl};
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++;
                $display("FAIL ctl cyc=%0d got rdy/busy/ill/done/we/mux=%b want %b",
                         cyc, got_ctl, exp_ctl);
            end
            if (age >= 1 && m_legal(mw)) begin
                e_rr1 = rs; e_sh = 5'd0;
                if (m_fixed_shift(mw[5:0])) begin e_rr1 = rt; e_sh = mw[10:6]; end
                else if (m_var(mw[5:0]) && age >= 2) begin e_rr1 = rt; e_sh = mvar_sh; end
                exp_ops = {e_rr1, rt, m_alu(mw[5:0]), e_sh};
                got_ops = {RR1, RR2, ALUOp, ShiftCount};
                checks++;
                if (got_ops !== exp_ops) begin
                    errors++;
                    $display("FAIL ops cyc=%0d got rr1/rr2/alu/sh=%h want %h",
                             cyc, got_ops, exp_ops);
                end
                if (age == 3) begin
                    checks++;
                    if (WR !== rd) begin
                        errors++;
                        $display("FAIL wr cyc=%0d got %0d want %0d", cyc, WR, rd);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Present a word; returns just after the accepting edge (cycle N+1).
    task automatic issue(input logic [31:0] w);
        @(posedge Clk); #1;
        InstrValid = 1'b1; Instr = w;
        @(posedge Clk); #1;
        InstrValid = 1'b0;
    endtask

    logic [31:0] table_w[10];
    int n0, c1;

    initial begin
        Rst = 1'b1; InstrValid = 1'b0; Instr = '0; RsData = 32'hFFFF_FF13;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("rst_rr1", RR1, 0);   chk("rst_rr2", RR2, 0);   chk("rst_wr", WR, 0);
        chk("rst_alu", ALUOp, 0); chk("rst_sh", ShiftCount, 0);
        chk("rst_ctl", {WE, MuxCtrl, Done, IllegalInstr, Busy}, 0);
        chk("rst_rdy", InstrReady, 1);

        issue(32'h0060_2820);                       // add $5,$3,$0
        @(negedge Clk);
        chk("add_rr1", RR1, 3); chk("add_rr2", RR2, 0); chk("add_alu", ALUOp, 0);
        chk("add_we_n1", WE, 0);
        @(negedge Clk); chk("add_we_n2", WE, 0);
        @(negedge Clk);
        chk("add_wb", {WE, WR, MuxCtrl, Done}, {1'b1, 5'd5, 1'b1, 1'b1});
        @(negedge Clk); chk("add_we_n4", WE, 0); chk("add_rdy_n4", InstrReady, 1);

        issue(32'h0000_2880);                       // sll $5,$0,2
        @(negedge Clk);
        chk("sll_rr1", RR1, 0); chk("sll_alu", ALUOp, 4); chk("sll_sh", ShiftCount, 2);
        @(negedge Clk); @(negedge Clk);
        chk("sll_wb", {WE, WR}, {1'b1, 5'd5});

        issue(32'h2000_0000);                       // op=8
        @(negedge Clk); chk("ill_pulse", IllegalInstr, 1); chk("ill_we", WE, 0);
        @(negedge Clk); chk("ill_rdy", InstrReady, 1); chk("ill_we2", WE, 0);

        issue(32'h0022_0020);                       // add $0,$1,$2
        @(negedge Clk); @(negedge Clk); @(negedge Clk);
        chk("rd0_done", Done, 1); chk("rd0_we", WE, 0);

        // Reset while in EXEC must swallow the writeback.
        n0 = we_cyc.size();
        issue(32'h0060_2820);
        @(posedge Clk); #1 Rst = 1'b1;
        @(posedge Clk); #1 Rst = 1'b0;
        @(negedge Clk);
        chk("abort_ops", {RR1, RR2, WR, ALUOp, ShiftCount}, 0);
        chk("abort_ctl", {WE, MuxCtrl, Done, IllegalInstr, Busy}, 0);
        chk("abort_rdy", InstrReady, 1);
        repeat (3) @(negedge Clk);
        chk("abort_no_we", we_cyc.size() - n0, 0);

        table_w[0] = mk(4, 6, 7, 0, 6'h22);
        table_w[1] = mk(8, 9, 10, 0, 6'h24);
        table_w[2] = mk(11, 12, 13, 0, 6'h25);
        table_w[3] = mk(0, 14, 15, 9, 6'h02);
        table_w[4] = mk(1, 16, 17, 31, 6'h03);
        table_w[5] = mk(18, 19, 20, 0, 6'h2B);
        table_w[6] = mk(21, 22, 31, 0, 6'h2A);
        table_w[7] = mk(23, 24, 25, 3, 6'h04);
        table_w[8] = mk(1, 2, 3, 0, 6'h21);
        table_w[9] = mk(26, 27, 28, 0, 6'h07);
        foreach (table_w[i]) begin
            issue(table_w[i]);
            repeat (3) @(negedge Clk);
        end
        @(negedge Clk);

        // Held valid across two words; the change during busy must be ignored.
        n0 = we_cyc.size();
        @(posedge Clk); #1;
        InstrValid = 1'b1; Instr = mk(1, 2, 7, 0, 6'h20);
        @(posedge Clk); #1;
        c1 = cyc;
        Instr = mk(3, 4, 9, 0, 6'h22);
        repeat (4) @(posedge Clk);
        #1 InstrValid = 1'b0;
        repeat (5) @(negedge Clk);
        chk("held_we_count", we_cyc.size() - n0, 2);
        if (we_cyc.size() - n0 == 2) begin
            chk("held_we1_cyc", we_cyc[n0], c1 + 2);
            chk("held_we2_cyc", we_cyc[n0 + 1], c1 + 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
